// File: rtl/biu_constants_pkg.sv
// Shared bus-interface constants: access size encoding and the byte-enable
// helper used by both the core LSU and the local data memory responder.
package biu_constants_pkg;

  typedef enum logic [2:0] {
    BYTE  = 3'd0,
    HWORD = 3'd1,
    WORD  = 3'd2,
    DWORD = 3'd3,
    QWORD = 3'd4
  } biu_size_t;

  // Lane mask for a 32-bit bus; unsupported sizes enable nothing.
  function automatic logic [3:0] biu_byte_enable(input biu_size_t size,
                                                 input logic [1:0] adr_lo);
    case (size)
      BYTE:    return 4'b0001 << adr_lo;
      HWORD:   return 4'b0011 << adr_lo;
      WORD:    return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ram_1rw.sv
// Single-port word RAM with per-byte write enables and a registered read.
// Behavioural model; technology builds swap in a macro with the same ports.
module dmem_ram_1rw #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 1024,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic [AW-1:0]       addr,
  input  logic                we,
  input  logic [XLEN/8-1:0]   be,
  input  logic [XLEN-1:0]     d,
  input  logic                re,
  output logic [XLEN-1:0]     q
);

  logic [XLEN-1:0] mem [DEPTH];

  // NOTE: no reset on the array or the read register -- a reset port here
  // would stop synthesis from mapping onto block RAM, and contents must
  // survive a core reset anyway.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < XLEN/8; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= d[8*i +: 8];
      end
    end
    if (re) q <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data memory target: accepts one access, waits
// WAIT_STATES cycles, then acks with error/misalignment status.
module dmem_responder
  import biu_constants_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              DEPTH       = 1024,
  parameter logic [XLEN-1:0] BASE_ADR    = '0,
  parameter int              WAIT_STATES = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dmem_req,
  input  logic [XLEN-1:0] dmem_adr,
  input  logic [XLEN-1:0] dmem_d,
  input  logic            dmem_we,
  input  biu_size_t       dmem_size,
  output logic [XLEN-1:0] dmem_q,
  output logic            dmem_ack,
  output logic            dmem_err,
  output logic            dmem_misaligned,
  output logic            dmem_page_fault
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state;
  logic [3:0]      wait_cnt;
  logic [XLEN-1:0] req_adr;
  logic [XLEN-1:0] req_d;
  logic            req_we;
  biu_size_t       req_size;
  logic            q_blank;
  logic [XLEN-1:0] ram_q;

  logic [XLEN-1:0] cur_adr;
  logic [XLEN-1:0] cur_off;
  biu_size_t       cur_size;
  logic            cur_bad_size;
  logic            cur_unaligned;
  logic            cur_oor;
  logic            cur_err;
  logic            cur_mis;
  logic            go_resp;

  // The access being checked is the bus in IDLE (zero-wait acceptance) and the
  // registered request otherwise, so status is ready on the edge into RESP.
  always_comb begin
    if (state == IDLE) begin
      cur_adr  = dmem_adr;
      cur_size = dmem_size;
    end else begin
      cur_adr  = req_adr;
      cur_size = req_size;
    end
    cur_off       = cur_adr - BASE_ADR;
    cur_bad_size  = !(cur_size inside {BYTE, HWORD, WORD});
    cur_unaligned = (cur_size == HWORD && cur_adr[0]) ||
                    (cur_size == WORD  && cur_adr[1:0] != 2'b00);
    cur_oor       = (cur_off >> (AW + 2)) != '0;
    cur_mis       = !cur_bad_size && cur_unaligned;
    cur_err       = cur_bad_size || (!cur_unaligned && cur_oor);
  end

  assign go_resp = (state == IDLE && dmem_req && WAIT_STATES == 0) ||
                   (state == WAIT && wait_cnt == 4'd0);

  // NOTE: all FSM state and registered outputs use non-blocking assignments so
  // every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      wait_cnt        <= 4'd0;
      req_adr         <= '0;
      req_d           <= '0;
      req_we          <= 1'b0;
      req_size        <= BYTE;
      dmem_ack        <= 1'b0;
      dmem_err        <= 1'b0;
      dmem_misaligned <= 1'b0;
      q_blank         <= 1'b1;
    end else begin
      dmem_ack        <= 1'b0;
      dmem_err        <= 1'b0;
      dmem_misaligned <= 1'b0;
      if (go_resp) begin
        dmem_ack        <= 1'b1;
        dmem_err        <= cur_err;
        dmem_misaligned <= cur_mis;
        q_blank         <= cur_err || cur_mis;
      end
      case (state)
        IDLE: begin
          if (dmem_req) begin
            req_adr  <= dmem_adr;
            req_d    <= dmem_d;
            req_we   <= dmem_we;
            req_size <= dmem_size;
            if (WAIT_STATES == 0) begin
              state <= RESP;
            end else begin
              state    <= WAIT;
              wait_cnt <= 4'(WAIT_STATES - 1);
            end
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) state <= RESP;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stores commit on the edge leaving RESP, before any next acceptance can read.
  dmem_ram_1rw #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk  (clk),
    .addr (AW'(cur_off >> 2)),
    .we   (state == RESP && req_we && !(dmem_err || dmem_misaligned)),
    .be   (biu_byte_enable(req_size, req_adr[1:0])),
    .d    (req_d),
    .re   (go_resp && !(cur_err || cur_mis)),
    .q    (ram_q)
  );

  assign dmem_q          = q_blank ? '0 : ram_q;
  assign dmem_page_fault = 1'b0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: two responders (0 and 3 wait states) sharing clock and reset.
module tb_dmem_responder;
  import biu_constants_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req    [2];
  logic [31:0] adr    [2];
  logic [31:0] d      [2];
  logic        we     [2];
  biu_size_t   size_v [2];
  logic [31:0] q      [2];
  logic        ack    [2];
  logic        err    [2];
  logic        mis    [2];
  logic        pf     [2];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.XLEN(32), .DEPTH(1024), .BASE_ADR(32'h0), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .dmem_req(req[0]), .dmem_adr(adr[0]), .dmem_d(d[0]),
    .dmem_we(we[0]), .dmem_size(size_v[0]), .dmem_q(q[0]), .dmem_ack(ack[0]),
    .dmem_err(err[0]), .dmem_misaligned(mis[0]), .dmem_page_fault(pf[0]));

  dmem_responder #(.XLEN(32), .DEPTH(1024), .BASE_ADR(32'h0), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst), .dmem_req(req[1]), .dmem_adr(adr[1]), .dmem_d(d[1]),
    .dmem_we(we[1]), .dmem_size(size_v[1]), .dmem_q(q[1]), .dmem_ack(ack[1]),
    .dmem_err(err[1]), .dmem_misaligned(mis[1]), .dmem_page_fault(pf[1]));

  function automatic int ws_of(input int s);
    return (s == 0) ? 0 : 3;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 'h%08h, expected 'h%08h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 one cycle after the ack cycle.
  task automatic xfer(input int s, input string tag, input logic w, input biu_size_t sz,
                      input logic [31:0] a, input logic [31:0] wd, input bit chk_q,
                      input logic [31:0] exp_q, input logic exp_err, input logic exp_mis);
    int lat;
    logic [31:0] rq;
    logic re, rm;
    lat = 0;
    req[s] = 1'b1; we[s] = w; size_v[s] = sz; adr[s] = a; d[s] = wd;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (ack[s]) begin
        lat = n;
        break;
      end
    end
    rq = q[s]; re = err[s]; rm = mis[s];
    req[s] = 1'b0;
    check({tag, "_latency"}, lat, 1 + ws_of(s));
    check({tag, "_err"}, re, exp_err);
    check({tag, "_mis"}, rm, exp_mis);
    if (chk_q) check({tag, "_q"}, rq, exp_q);
    @(posedge clk); #1;
    check({tag, "_ack_pulse"}, ack[s], 1'b0);
    check({tag, "_err_clear"}, err[s] | mis[s], 1'b0);
  endtask

  // Four loads with dmem_req held high throughout.
  task automatic b2b(input int s);
    int cnt, last, cyc, extra;
    cnt = 0; last = 0; cyc = 0; extra = 0;
    req[s] = 1'b1; we[s] = 1'b0; size_v[s] = WORD; adr[s] = 32'h40; d[s] = '0;
    for (int c = 0; c < 80 && cnt < 4; c++) begin
      @(posedge clk); #1;
      cyc++;
      if (ack[s]) begin
        check($sformatf("b2b%0d_q%0d", s, cnt), q[s], 32'hA5A5_0000 | 32'(cnt));
        if (cnt > 0) check($sformatf("b2b%0d_space%0d", s, cnt), cyc - last, 2 + ws_of(s));
        last = cyc;
        cnt++;
        if (cnt < 4) adr[s] = 32'h40 + 32'(4 * cnt);
        else         req[s] = 1'b0;
      end
    end
    req[s] = 1'b0;
    check($sformatf("b2b%0d_count", s), cnt, 4);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (ack[s]) extra++;
    end
    check($sformatf("b2b%0d_extra", s), extra, 0);
  endtask

  initial begin
    int stray;
    for (int s = 0; s < 2; s++) begin
      req[s] = 1'b0; adr[s] = '0; d[s] = '0; we[s] = 1'b0; size_v[s] = WORD;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    for (int s = 0; s < 2; s++) begin
      check($sformatf("rst%0d_q", s), q[s], 32'h0);
      check($sformatf("rst%0d_ack", s), ack[s], 1'b0);
      check($sformatf("rst%0d_err", s), err[s], 1'b0);
      check($sformatf("rst%0d_mis", s), mis[s], 1'b0);
      check($sformatf("rst%0d_pf", s), pf[s], 1'b0);
    end

    // Zero wait states: basic store/load and the flagged cases
    xfer(0, "sw10",    1'b1, WORD,  32'h10,   32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 1'b0);
    xfer(0, "lw10",    1'b0, WORD,  32'h10,   32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    xfer(0, "sh13",    1'b1, HWORD, 32'h13,   32'h1234_5678, 1'b1, 32'h0, 1'b0, 1'b1);
    xfer(0, "sw12",    1'b1, WORD,  32'h12,   32'h0,         1'b0, 32'h0, 1'b0, 1'b1);
    xfer(0, "sw_oor",  1'b1, WORD,  32'h1010, 32'h0BAD_0BAD, 1'b0, 32'h0, 1'b1, 1'b0);
    xfer(0, "lw10b",   1'b0, WORD,  32'h10,   32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    xfer(0, "lw_oor",  1'b0, WORD,  32'h1000, 32'h0,         1'b1, 32'h0, 1'b1, 1'b0);
    xfer(0, "lw10c",   1'b0, WORD,  32'h10,   32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    xfer(0, "ld_dw",   1'b0, DWORD, 32'h10,   32'h0,         1'b1, 32'h0, 1'b1, 1'b0);

    // Three wait states: byte lane store and half-word load of a full word
    xfer(1, "sw20",    1'b1, WORD,  32'h20,   32'h0,         1'b0, 32'h0, 1'b0, 1'b0);
    xfer(1, "sb21",    1'b1, BYTE,  32'h21,   32'hAAAA_AAAA, 1'b0, 32'h0, 1'b0, 1'b0);
    xfer(1, "lw20",    1'b0, WORD,  32'h20,   32'h0,         1'b1, 32'h0000_AA00, 1'b0, 1'b0);
    xfer(1, "lh22",    1'b0, HWORD, 32'h22,   32'h0,         1'b1, 32'h0000_AA00, 1'b0, 1'b0);
    xfer(1, "sh_hi",   1'b1, HWORD, 32'h22,   32'h5566_7788, 1'b0, 32'h0, 1'b0, 1'b0);
    xfer(1, "lw20b",   1'b0, WORD,  32'h20,   32'h0,         1'b1, 32'h5566_AA00, 1'b0, 1'b0);
    xfer(1, "lw_mis",  1'b0, WORD,  32'h21,   32'h0,         1'b1, 32'h0, 1'b0, 1'b1);

    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 4; i++) begin
        xfer(s, $sformatf("pre%0d_%0d", s, i), 1'b1, WORD, 32'h40 + 32'(4 * i),
             32'hA5A5_0000 | 32'(i), 1'b0, 32'h0, 1'b0, 1'b0);
      end
      b2b(s);
    end

    // Reset in the middle of a store's wait states abandons it
    xfer(1, "sw30", 1'b1, WORD, 32'h30, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 1'b0);
    req[1] = 1'b1; we[1] = 1'b1; size_v[1] = WORD; adr[1] = 32'h30; d[1] = 32'hCAFE_F00D;
    @(posedge clk);
    @(posedge clk); #1;
    check("rstw_pre_ack", ack[1], 1'b0);
    rst = 1'b1;
    #1;
    check("rstw_q", q[1], 32'h0);
    check("rstw_ack", ack[1], 1'b0);
    check("rstw_err", err[1] | mis[1], 1'b0);
    req[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    stray = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (ack[1]) stray++;
    end
    check("rstw_no_ack", stray, 0);
    xfer(1, "lw30", 1'b0, WORD, 32'h30, 32'h0, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
    xfer(0, "lw10d", 1'b0, WORD, 32'h10, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
